// File: rtl/pixel_coord_pkg.sv
// Shared definitions for the pixel coordinate tracker: FSM state type,
// default OLED geometry and a ceil(log2) helper used for width checks.
package pixel_coord_pkg;

  localparam int unsigned OLED_WIDTH  = 96;
  localparam int unsigned OLED_HEIGHT = 64;
  localparam int unsigned OLED_IDX_W  = 13;

  typedef enum logic [0:0] {
    TRACK  = 1'b0,
    DIVIDE = 1'b1
  } coord_state_t;

  // Smallest r such that 2^r >= value.
  function automatic int unsigned clog2_u(input int unsigned value);
    int unsigned     res;
    longint unsigned pow;
    res = 0;
    pow = 1;
    while (pow < longint'(value)) begin
      pow = pow << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pixel_coord_tracker_if.sv
// Pixel index / coordinate bundle between the display driver (master) and
// the coordinate tracker (slave). frame_tick exists only when
// COORD_FRAME_TICK_EN is defined.
interface pixel_coord_tracker_if #(
  parameter int unsigned IDX_W = 13,
  parameter int unsigned X_W   = 7,
  parameter int unsigned Y_W   = 6
);

  logic [IDX_W-1:0] pixel_index;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             valid;
  logic             out_of_range;
`ifdef COORD_FRAME_TICK_EN
  logic             frame_tick;

  modport master (
    output pixel_index,
    input  x, y, valid, out_of_range, frame_tick
  );

  modport slave (
    input  pixel_index,
    output x, y, valid, out_of_range, frame_tick
  );
`else
  modport master (
    output pixel_index,
    input  x, y, valid, out_of_range
  );

  modport slave (
    input  pixel_index,
    output x, y, valid, out_of_range
  );
`endif

endinterface

// File: rtl/pixel_coord_tracker_serial_divider.sv
// Serial restoring divider: one quotient bit per cycle, IDX_W steps.
// The first step is folded into the start cycle, so done (with quotient and
// remainder) is high for one cycle after IDX_W clock edges counting the
// start edge.
module serial_divider
  import pixel_coord_pkg::*;
#(
  parameter int unsigned IDX_W = OLED_IDX_W,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned Q_W   = IDX_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [IDX_W-1:0] i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_done,
  output logic [Q_W-1:0]   o_quotient,
  output logic [DIV_W-1:0] o_remainder
);

  localparam int unsigned CNT_W = clog2_u(IDX_W) + 1;

  if (IDX_W < 2) begin : g_bad_idx_w
    $error("serial_divider: IDX_W must be at least 2");
  end
  if (Q_W > IDX_W) begin : g_bad_q_w
    $error("serial_divider: Q_W must not exceed IDX_W");
  end

  logic [DIV_W-1:0] r_rem;
  logic [IDX_W-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [DIV_W-1:0] w_src_rem;
  logic [IDX_W-1:0] w_src_quo;
  logic [DIV_W:0]   w_trial;
  logic [DIV_W:0]   w_diff;
  logic             w_ge;
  logic [DIV_W-1:0] w_rem_nxt;
  logic [IDX_W-1:0] w_quo_nxt;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. r_quo holds the unused
  // dividend bits at the top and the growing quotient at the bottom.
  always_comb begin
    w_src_rem = i_start ? '0 : r_rem;
    w_src_quo = i_start ? i_dividend : r_quo;
    w_trial   = {w_src_rem, w_src_quo[IDX_W-1]};
    w_ge      = (w_trial >= {1'b0, i_divisor});
    w_diff    = w_trial - {1'b0, i_divisor};
    w_rem_nxt = w_ge ? DIV_W'(w_diff) : DIV_W'(w_trial);
    w_quo_nxt = {w_src_quo[IDX_W-2:0], w_ge};
  end

  // Step sequencer; a start always restarts, reset aborts immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= CNT_W'(IDX_W - 1);
      end else if (r_cnt != '0) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_quo[Q_W-1:0];
  assign o_remainder = r_rem;

endmodule

// File: rtl/pixel_coord_tracker.sv
// Linear pixel index -> registered (x, y). Sequential scans take a one-cycle
// incremental path; any other in-range jump runs the serial divider.
// Optional feature macro: COORD_FRAME_TICK_EN (adds the frame_tick pulse on
// a sequential wrap from the last pixel to (0,0)).
module pixel_coord_tracker
  import pixel_coord_pkg::*;
#(
  parameter int unsigned WIDTH  = OLED_WIDTH,
  parameter int unsigned HEIGHT = OLED_HEIGHT,
  parameter int unsigned IDX_W  = OLED_IDX_W,
  parameter int unsigned X_W    = 7,
  parameter int unsigned Y_W    = 6
) (
  input logic                  clock,
  input logic                  reset,
  pixel_coord_tracker_if.slave coord
);

  localparam int unsigned N     = WIDTH * HEIGHT;
  localparam int unsigned DIV_W = X_W + 1;

  localparam logic [IDX_W:0]   LP_N       = (IDX_W+1)'(N);
  localparam logic [IDX_W:0]   LP_LAST    = (IDX_W+1)'(N - 1);
  localparam logic [X_W-1:0]   LP_X_MAX   = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]   LP_Y_MAX   = Y_W'(HEIGHT - 1);
  localparam logic [DIV_W-1:0] LP_DIVISOR = DIV_W'(WIDTH);

  if (clog2_u(N) > IDX_W) begin : g_bad_idx_w
    $error("pixel_coord_tracker: IDX_W too small for WIDTH*HEIGHT");
  end
  if (clog2_u(WIDTH) > X_W) begin : g_bad_x_w
    $error("pixel_coord_tracker: X_W too small for WIDTH");
  end
  if (clog2_u(HEIGHT) > Y_W) begin : g_bad_y_w
    $error("pixel_coord_tracker: Y_W too small for HEIGHT");
  end

  coord_state_t     r_state, w_state_nxt;
  logic [IDX_W-1:0] r_last_idx, w_last_idx_nxt;
  logic [IDX_W-1:0] r_div_idx, w_div_idx_nxt;
  logic             r_last_ok, w_last_ok_nxt;
  logic [X_W-1:0]   r_x, w_x_nxt;
  logic [Y_W-1:0]   r_y, w_y_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_oor, w_oor_nxt;
`ifdef COORD_FRAME_TICK_EN
  logic             r_tick, w_tick_nxt;
`endif

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W:0]   w_idx_ext;
  logic [IDX_W:0]   w_last_ext;
  logic             w_in_range;
  logic             w_hold;
  logic             w_seq;
  logic             w_div_start;
  logic             w_div_done;
  logic [Y_W-1:0]   w_quo;
  logic [DIV_W-1:0] w_rem;
  logic             w_unused_rem_msb;

  assign w_idx      = coord.pixel_index;
  assign w_idx_ext  = {1'b0, w_idx};
  assign w_last_ext = {1'b0, r_last_idx};
  assign w_in_range = (w_idx_ext < LP_N);
  assign w_hold     = r_last_ok && (w_idx == r_last_idx);
  assign w_seq      = r_last_ok &&
                      ((w_idx_ext == w_last_ext + (IDX_W+1)'(1)) ||
                       ((w_last_ext == LP_LAST) && (w_idx == '0)));

  // remainder < WIDTH <= 2^X_W, so its top bit is always zero
  assign w_unused_rem_msb = w_rem[X_W];

  serial_divider #(
    .IDX_W (IDX_W),
    .DIV_W (DIV_W),
    .Q_W   (Y_W)
  ) u_div (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_start     (w_div_start),
    .i_dividend  (w_idx),
    .i_divisor   (LP_DIVISOR),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= TRACK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode for TRACK/DIVIDE.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_idx_nxt = r_last_idx;
    w_div_idx_nxt  = r_div_idx;
    w_last_ok_nxt  = r_last_ok;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_valid_nxt    = r_valid;
    w_oor_nxt      = r_oor;
    w_div_start    = 1'b0;
`ifdef COORD_FRAME_TICK_EN
    w_tick_nxt     = 1'b0;
`endif
    case (r_state)
      TRACK: begin
        if (!w_in_range) begin
          w_oor_nxt     = 1'b1;
          w_valid_nxt   = 1'b0;
          w_last_ok_nxt = 1'b0;
        end else if (w_hold) begin
          w_state_nxt = TRACK;
        end else if (w_seq) begin
          w_last_idx_nxt = w_idx;
          w_valid_nxt    = 1'b1;
          w_oor_nxt      = 1'b0;
          if (r_x == LP_X_MAX) begin
            w_x_nxt = '0;
            if (r_y == LP_Y_MAX) begin
              w_y_nxt = '0;
`ifdef COORD_FRAME_TICK_EN
              w_tick_nxt = 1'b1;
`endif
            end else begin
              w_y_nxt = r_y + Y_W'(1);
            end
          end else begin
            w_x_nxt = r_x + X_W'(1);
          end
        end else begin
          w_div_start   = 1'b1;
          w_div_idx_nxt = w_idx;
          w_valid_nxt   = 1'b0;
          w_oor_nxt     = 1'b0;
          w_state_nxt   = DIVIDE;
        end
      end
      DIVIDE: begin
        if (w_div_done) begin
          w_x_nxt        = w_rem[X_W-1:0];
          w_y_nxt        = w_quo;
          w_last_idx_nxt = r_div_idx;
          w_last_ok_nxt  = 1'b1;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = TRACK;
        end
      end
      default: begin
        w_state_nxt = TRACK;
      end
    endcase
  end

  // Registered coordinates and tracking context.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_idx <= '0;
      r_div_idx  <= '0;
      r_last_ok  <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_valid    <= 1'b0;
      r_oor      <= 1'b0;
`ifdef COORD_FRAME_TICK_EN
      r_tick     <= 1'b0;
`endif
    end else begin
      r_last_idx <= w_last_idx_nxt;
      r_div_idx  <= w_div_idx_nxt;
      r_last_ok  <= w_last_ok_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_valid    <= w_valid_nxt;
      r_oor      <= w_oor_nxt;
`ifdef COORD_FRAME_TICK_EN
      r_tick     <= w_tick_nxt;
`endif
    end
  end

  assign coord.x            = r_x;
  assign coord.y            = r_y;
  assign coord.valid        = r_valid;
  assign coord.out_of_range = r_oor;
`ifdef COORD_FRAME_TICK_EN
  assign coord.frame_tick   = r_tick;
`endif

endmodule

// File: tb/tb_pixel_coord_tracker.sv
// Bench for pixel_coord_tracker: directed scenarios plus random index
// streams compared against a reference model that derives (x, y) as
// index % WIDTH and index / WIDTH. A second instance covers 128x32 geometry.
module tb_pixel_coord_tracker;

  localparam int W   = 96;
  localparam int H   = 64;
  localparam int IW  = 13;
  localparam int N   = W * H;

  localparam int W2  = 128;
  localparam int H2  = 32;
  localparam int IW2 = 12;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic reset2 = 1'b1;

  always #5 clock = ~clock;

  pixel_coord_tracker_if #(.IDX_W(IW), .X_W(7), .Y_W(6)) bus ();
  pixel_coord_tracker_if #(.IDX_W(IW2), .X_W(7), .Y_W(5)) bus2 ();

  pixel_coord_tracker #(
    .WIDTH (W), .HEIGHT (H), .IDX_W (IW), .X_W (7), .Y_W (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .coord (bus)
  );

  pixel_coord_tracker #(
    .WIDTH (W2), .HEIGHT (H2), .IDX_W (IW2), .X_W (7), .Y_W (5)
  ) dut2 (
    .clock (clock),
    .reset (reset2),
    .coord (bus2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_wait, m_pend, m_last, m_ok;
  int e_x, e_y, e_valid, e_oor, e_tick;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_pend = 0; m_last = 0; m_ok = 0;
    e_x = 0; e_y = 0; e_valid = 0; e_oor = 0; e_tick = 0;
  endtask

  // Expected effect of one clock edge that samples index idx.
  task automatic model_edge(input int idx);
    e_tick = 0;
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        e_x = m_pend % W;
        e_y = m_pend / W;
        e_valid = 1;
        m_last = m_pend;
        m_ok = 1;
      end
    end else if (idx >= N) begin
      e_oor = 1; e_valid = 0; m_ok = 0;
    end else if (m_ok != 0 && idx == m_last) begin
      e_tick = 0;
    end else if (m_ok != 0 && (idx == m_last + 1 || (m_last == N - 1 && idx == 0))) begin
      m_last = idx;
      e_x = idx % W;
      e_y = idx / W;
      e_valid = 1; e_oor = 0;
      e_tick = (idx == 0) ? 1 : 0;
    end else begin
      m_pend = idx; m_wait = IW;
      e_valid = 0; e_oor = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x"}, int'(bus.x), e_x);
    chk({tag, ".y"}, int'(bus.y), e_y);
    chk({tag, ".valid"}, int'(bus.valid), e_valid);
    chk({tag, ".oor"}, int'(bus.out_of_range), e_oor);
`ifdef COORD_FRAME_TICK_EN
    chk({tag, ".tick"}, int'(bus.frame_tick), e_tick);
`endif
  endtask

  task automatic step(input string tag, input int idx);
    bus.pixel_index = IW'(idx);
    @(posedge clock);
    #1;
    model_edge(idx);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    check_all(tag);
    reset = 1'b0;
  endtask

  int r, nxt, cnt;

  initial begin
    bus.pixel_index  = '0;
    bus2.pixel_index = '0;
    model_reset();

    // reset state
    do_reset("rst");

    // index 0 divides, then sequential scan 1..97
    repeat (IW + 1) step("idx0", 0);
    chk("idx0_valid", int'(bus.valid), 1);
    for (int i = 1; i <= 97; i++) step("scan", i);
    chk("scan_end_x", int'(bus.x), 1);
    chk("scan_end_y", int'(bus.y), 1);

    // track at 100, jump to last pixel, wrap to 0
    repeat (IW + 1) step("at100", 100);
    step("jump6143", 6143);
    repeat (IW) step("div6143", 6143);
    chk("last_x", int'(bus.x), 95);
    chk("last_y", int'(bus.y), 63);
    step("wrap0", 0);
    chk("wrap_valid", int'(bus.valid), 1);

    // out-of-range handling and recovery via divide
    step("oor6144", 6144);
    chk("oor_flag", int'(bus.out_of_range), 1);
    step("oor6145", 6145);
    repeat (IW + 1) step("div200", 200);
    chk("d200_x", int'(bus.x), 8);
    chk("d200_y", int'(bus.y), 2);

    // pixel_index churns during a divide of 500
    step("start500", 500);
    repeat (IW) step("churn", int'($urandom_range(0, 8191)));
    chk("d500_x", int'(bus.x), 20);
    chk("d500_y", int'(bus.y), 5);
    step("hold500", 500);
    step("jump1000", 1000);
    chk("redivide_valid", int'(bus.valid), 0);
    repeat (IW) step("div1000", 1000);

    // reset on cycle 5 of a divide, then no stale result
    step("start3000", 3000);
    repeat (4) step("mid3000", int'($urandom_range(0, 8191)));
    do_reset("rst_mid_div");
    repeat (IW + 4) step("after_rst", 3000);

    // random streams: runs, holds, jumps, near-wrap, out of range
    for (int k = 0; k < 500; k++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4) nxt = (m_last == N - 1) ? 0 : m_last + 1;
      else if (r <= 6) nxt = m_last;
      else if (r == 7) nxt = int'($urandom_range(0, N - 1));
      else if (r == 8) nxt = N - 1 - int'($urandom_range(0, 2));
      else nxt = int'($urandom_range(N, 8191));
      step("rand", nxt);
    end

    // alternate geometry 128x32, IDX_W=12
    reset2 = 1'b1;
    @(posedge clock);
    #1;
    chk("g2_rst_valid", int'(bus2.valid), 0);
    chk("g2_rst_x", int'(bus2.x), 0);
    reset2 = 1'b0;
    bus2.pixel_index = IW2'(4095);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      #1;
      cnt++;
      if (bus2.valid) break;
    end
    chk("g2_latency", cnt, IW2 + 1);
    chk("g2_x", int'(bus2.x), (4095 % W2));
    chk("g2_y", int'(bus2.y), (4095 / W2));
    bus2.pixel_index = '0;
    @(posedge clock);
    #1;
    chk("g2_wrap_x", int'(bus2.x), 0);
    chk("g2_wrap_y", int'(bus2.y), 0);
    chk("g2_wrap_valid", int'(bus2.valid), 1);
`ifdef COORD_FRAME_TICK_EN
    chk("g2_wrap_tick", int'(bus2.frame_tick), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_coord_tracker.md
# pixel_coord_tracker

Registered converter from a linear OLED pixel index to (x, y) coordinates for arbitrary display geometry. It replaces the fixed divide-by-96 row extractor. Sequential scans use an incremental fast path with one-cycle latency. Any non-sequential jump falls back to a serial restoring divider, so there is no combinational divider in the pixel path. It sits between the display driver's pixel_index output and the pixel-colour logic.

## Interface
- WIDTH, 96, pixels per row
- HEIGHT, 64, rows per frame
- IDX_W, 13, pixel_index width; must satisfy 2^IDX_W >= WIDTH*HEIGHT
- X_W, 7, x width; must satisfy 2^X_W >= WIDTH
- Y_W, 6, y width; must satisfy 2^Y_W >= HEIGHT

Ports (clock and reset first):
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- pixel_index  in  IDX_W  linear index, row-major
- x  out  X_W  column, registered
- y  out  Y_W  row, registered
- valid  out  1  high when x/y correspond to the last accepted index
- out_of_range  out  1  high while the accepted index is >= WIDTH*HEIGHT
- frame_tick  out  1  only with COORD_FRAME_TICK_EN; one-cycle pulse

## Operation
- States: TRACK, DIVIDE.
- Internal registers: last_idx (IDX_W bits) and last_ok (1 bit).

In TRACK, each edge samples pixel_index as i, with N = WIDTH*HEIGHT:
- **Out of range (i >= N):** out_of_range=1, valid=0, last_ok=0; x/y hold.
- **Hold (last_ok and i == last_idx):** all outputs hold.
- **Sequential (last_ok and i == last_idx+1, or last_idx == N-1 and i == 0):** last_idx=i; x=x+1.
  - At x == WIDTH-1: x=0, y=y+1.
  - At y == HEIGHT-1 on that row wrap: y=0.
  - valid=1, out_of_range=0.
- **Otherwise:** latch i into the divider, valid=0, out_of_range=0, go to DIVIDE.

DIVIDE:
- Restoring division of the latched i by WIDTH, one quotient bit per cycle, IDX_W cycles.
- pixel_index is ignored throughout.
- On the final step: x=remainder, y=quotient, last_idx=latched i, last_ok=1, valid=1; return to TRACK.
- The next TRACK sample then applies the rules above. A changed index re-divides unless it is last_idx+1.

Reset:
- x=0, y=0, valid=0, out_of_range=0, frame_tick=0.
- last_ok=0, state=TRACK.
- The first in-range index after reset always divides, including index 0.
- Reset during DIVIDE aborts the division immediately; no partial result reaches the outputs.

Arithmetic rules:
- Divider remainder register is X_W+1 bits wide.
- Quotient is truncated to Y_W bits. It is always in range because i < N.

## Timing
- Sequential or hold: x/y/valid update on the same edge that samples pixel_index, i.e. one-cycle latency, matching the legacy row extractor.
- Jump: sample at edge k; DIVIDE on edges k+1..k+IDX_W; results valid after edge k+IDX_W, so valid is low for IDX_W cycles.
- An out-of-range input takes effect on the sampling edge.
- Simultaneous reset and any other event: reset wins.

## Configuration
- COORD_FRAME_TICK_EN defined:
  - The frame_tick port exists.
  - It pulses high for exactly one cycle on the edge where the sequential path wraps (WIDTH-1, HEIGHT-1) to (0,0).
  - A divide that lands on (0,0) does not pulse it.
  - Reset value is 0.
- COORD_FRAME_TICK_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package pixel_coord_pkg holds:
  - the state enum (TRACK, DIVIDE);
  - default geometry constants (OLED_WIDTH=96, OLED_HEIGHT=64, OLED_IDX_W=13);
  - a function returning ceil(log2) for width checks.
- One natural sub-module: serial_divider (parameters IDX_W, divisor width), with a start/done handshake:
  - start pulses for one cycle with the dividend;
  - done pulses for one cycle together with the quotient and remainder;
  - a synchronous reset clears it.

## Test plan
Defaults unless noted.
- Reset, then drive indices 0..97 one per cycle:
  - valid is low for 13 cycles after index 0, then (0,0);
  - 1..97 follow with one-cycle latency, including (95,0) → (0,1) and ending at (1,1).
- From a tracked state at 100, jump to 6143:
  - valid is low for exactly 13 cycles, then (95,63);
  - next index 0 gives (0,0) via the fast path, and frame_tick pulses once if enabled.
- Drive index 6144:
  - out_of_range=1 and valid=0 on the next edge;
  - then index 6145 → still out of range;
  - then index 200 → divide, result (8,2).
- Change pixel_index every cycle during a DIVIDE of 500:
  - the result is (20,5);
  - the subsequent non-sequential index triggers a fresh divide.
- Assert reset on cycle 5 of a DIVIDE: all outputs are 0 on the next edge, and no stale result appears later.
- Parameters WIDTH=128, HEIGHT=32, IDX_W=12: index 4095 → (127,31); sequential 4095 → 0 wraps to (0,0).
